// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the writeback path: scoreboard id width and the
// {sid, rd, value} record carried from the execution units to the register file.
package wb_arbiter_pkg;

  localparam int SCOREBOARD_SIZE_WIDTH = 3;
  localparam int SID_W                 = SCOREBOARD_SIZE_WIDTH + 1;
  localparam int REG_ADDR_W            = 5;
  localparam int XLEN                  = 64;

  typedef struct packed {
    logic [SID_W-1:0]      sid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
  } wb_entry_t;

  // x0 is hardwired to zero, so a result targeting it completes without a write.
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO buffering ALU results; head is read combinationally so
// an entry becomes visible the cycle after it is written.
module wb_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Storage carries no reset; count and pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between buffered ALU results and the LSU
// handshake, registering one winner per cycle onto the register-file port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 4,
  parameter int SID_W          = wb_arbiter_pkg::SID_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             alu_exe_valid_i,
  input  logic [SID_W-1:0] alu_sid_i,
  input  logic [4:0]       alu_exe_rd_i,
  input  logic [63:0]      alu_exe_rd_value_i,
  output logic             alu_almost_full_o,
  input  logic             lsu_valid_i,
  output logic             lsu_ready_o,
  input  logic [SID_W-1:0] lsu_sid_i,
  input  logic [4:0]       lsu_rd_i,
  input  logic [63:0]      lsu_rd_value_i,
  output logic             wb_valid_o,
  output logic             wb_we_o,
  output logic [SID_W-1:0] wb_sid_o,
  output logic [4:0]       wb_rd_o,
  output logic [63:0]      wb_rd_value_o,
  output logic             err_overflow_o
);

  localparam int CNT_W = $clog2(ALU_FIFO_DEPTH) + 1;

  wb_entry_t        alu_entry;
  wb_entry_t        lsu_entry;
  wb_entry_t        alu_head;
  wb_entry_t        grant_entry;
  wb_entry_t        wb_entry_reg;
  logic [CNT_W-1:0] alu_count;
  logic             alu_cand;
  logic             alu_grant;
  logic             lsu_grant;
  logic             alu_push_ok;
  logic             alu_push_drop;
  logic             prio_lsu_reg;
  logic             wb_valid_reg;
  logic             err_overflow_reg;

  assign alu_entry = '{sid: alu_sid_i, rd: alu_exe_rd_i, value: alu_exe_rd_value_i};
  assign lsu_entry = '{sid: lsu_sid_i, rd: lsu_rd_i, value: lsu_rd_value_i};

  assign alu_cand = alu_count != '0;

  // Ready comes only from registered state and flush, so the LSU never sees a
  // combinational path from its own valid back to ready.
  assign lsu_ready_o = !flush_i && (!alu_cand || prio_lsu_reg);
  assign lsu_grant   = lsu_valid_i && lsu_ready_o;
  assign alu_grant   = !flush_i && alu_cand && !lsu_grant;

  // A full buffer still takes a push when its head leaves in the same cycle.
  assign alu_push_ok   = alu_exe_valid_i && !flush_i &&
                         ((alu_count < CNT_W'(ALU_FIFO_DEPTH)) || alu_grant);
  assign alu_push_drop = alu_exe_valid_i && !flush_i && !alu_push_ok;

  assign alu_almost_full_o = alu_count >= CNT_W'(ALU_FIFO_DEPTH - 1);

  assign grant_entry = lsu_grant ? lsu_entry : alu_head;

  wb_sync_fifo #(
    .DEPTH (ALU_FIFO_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_push_ok),
    .pop       (alu_grant),
    .flush     (flush_i),
    .push_data (alu_entry),
    .count     (alu_count),
    .head      (alu_head)
  );

  // The pointer only moves on contended cycles, so a lone requester never
  // steals the other side's next turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_lsu_reg <= 1'b0;
    end else if (flush_i) begin
      prio_lsu_reg <= 1'b0;
    end else if (alu_cand && lsu_valid_i) begin
      prio_lsu_reg <= !prio_lsu_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_reg <= 1'b0;
      wb_entry_reg <= '0;
    end else if (flush_i) begin
      wb_valid_reg <= 1'b0;
    end else begin
      wb_valid_reg <= alu_grant || lsu_grant;
      if (alu_grant || lsu_grant) begin
        wb_entry_reg <= grant_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_reg <= 1'b0;
    end else if (alu_push_drop) begin
      err_overflow_reg <= 1'b1;
    end
  end

  assign wb_valid_o     = wb_valid_reg;
  assign wb_we_o        = wb_valid_reg && writes_reg(wb_entry_reg.rd);
  assign wb_sid_o       = wb_entry_reg.sid;
  assign wb_rd_o        = wb_entry_reg.rd;
  assign wb_rd_value_o  = wb_entry_reg.value;
  assign err_overflow_o = err_overflow_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the writeback arbitration rules.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int SW    = wb_arbiter_pkg::SID_W;

  typedef struct packed {
    logic [SW-1:0] sid;
    logic [4:0]    rd;
    logic [63:0]   val;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic          alu_exe_valid_i;
  logic [SW-1:0] alu_sid_i;
  logic [4:0]    alu_exe_rd_i;
  logic [63:0]   alu_exe_rd_value_i;
  logic          alu_almost_full_o;
  logic          lsu_valid_i;
  logic          lsu_ready_o;
  logic [SW-1:0] lsu_sid_i;
  logic [4:0]    lsu_rd_i;
  logic [63:0]   lsu_rd_value_i;
  logic          wb_valid_o;
  logic          wb_we_o;
  logic [SW-1:0] wb_sid_o;
  logic [4:0]    wb_rd_o;
  logic [63:0]   wb_rd_value_o;
  logic          err_overflow_o;

  int n_vec = 0;
  int n_err = 0;

  wb_arbiter #(.ALU_FIFO_DEPTH(DEPTH), .SID_W(SW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_i            (flush_i),
    .alu_exe_valid_i    (alu_exe_valid_i),
    .alu_sid_i          (alu_sid_i),
    .alu_exe_rd_i       (alu_exe_rd_i),
    .alu_exe_rd_value_i (alu_exe_rd_value_i),
    .alu_almost_full_o  (alu_almost_full_o),
    .lsu_valid_i        (lsu_valid_i),
    .lsu_ready_o        (lsu_ready_o),
    .lsu_sid_i          (lsu_sid_i),
    .lsu_rd_i           (lsu_rd_i),
    .lsu_rd_value_i     (lsu_rd_value_i),
    .wb_valid_o         (wb_valid_o),
    .wb_we_o            (wb_we_o),
    .wb_sid_o           (wb_sid_o),
    .wb_rd_o            (wb_rd_o),
    .wb_rd_value_o      (wb_rd_value_o),
    .err_overflow_o     (err_overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    flush_i = 0; alu_exe_valid_i = 0; lsu_valid_i = 0;
    alu_sid_i = '0; alu_exe_rd_i = '0; alu_exe_rd_value_i = '0;
    lsu_sid_i = '0; lsu_rd_i = '0; lsu_rd_value_i = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic push_alu(input int sid, input int rd, input logic [63:0] v);
    alu_exe_valid_i = 1; alu_sid_i = SW'(sid); alu_exe_rd_i = 5'(rd); alu_exe_rd_value_i = v;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_vec++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o); end
    n_vec++; if (wb_we_o !== 1'b0) begin n_err++; $display("FAIL reset_wb_we: got %b want 0", wb_we_o); end
    n_vec++; if (err_overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_overflow_o); end
    n_vec++; if ({wb_sid_o, wb_rd_o, wb_rd_value_o} !== '0) begin n_err++; $display("FAIL reset_wb_data: got %0h/%0h/%0h want 0", wb_sid_o, wb_rd_o, wb_rd_value_o); end
    n_vec++; if (alu_almost_full_o !== 1'b0) begin n_err++; $display("FAIL reset_almost_full: got %b want 0", alu_almost_full_o); end
    n_vec++; if (lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_lsu_ready: got %b want 1", lsu_ready_o); end
    tick();
  endtask

  task automatic test_alu_only();
    apply_reset();
    push_alu(3, 5, 64'h1234);
    tick();
    alu_exe_valid_i = 0; #1;
    n_vec++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL alu_only_c1_valid: got %b want 0", wb_valid_o); end
    tick(); #1;
    n_vec++; if (wb_valid_o !== 1'b1 || wb_we_o !== 1'b1) begin n_err++; $display("FAIL alu_only_c2_strobe: got v=%b we=%b want 1/1", wb_valid_o, wb_we_o); end
    n_vec++; if (wb_sid_o !== SW'(3) || wb_rd_o !== 5'd5 || wb_rd_value_o !== 64'h1234) begin
      n_err++; $display("FAIL alu_only_c2_data: got sid=%0d rd=%0d val=%0h want 3/5/1234", wb_sid_o, wb_rd_o, wb_rd_value_o); end
    tick(); #1;
    n_vec++; if (wb_valid_o !== 1'b0 || wb_rd_o !== 5'd5 || wb_rd_value_o !== 64'h1234) begin
      n_err++; $display("FAIL alu_only_hold: got v=%b rd=%0d val=%0h want 0/5/1234", wb_valid_o, wb_rd_o, wb_rd_value_o); end
    tick();
  endtask

  task automatic test_contention();
    logic        exp_ready [4];
    logic [63:0] exp_wb [5];
    exp_ready[0] = 0; exp_ready[1] = 1; exp_ready[2] = 0; exp_ready[3] = 1;
    exp_wb[0] = 64'h102; exp_wb[1] = 64'hB0; exp_wb[2] = 64'h104; exp_wb[3] = 64'hC0; exp_wb[4] = 64'h106;
    apply_reset();
    lsu_sid_i = SW'(9); lsu_rd_i = 5'd9;
    push_alu(1, 1, 64'hA0); tick();
    push_alu(2, 2, 64'hB0); lsu_valid_i = 1; lsu_rd_value_i = 64'h101; tick();
    push_alu(3, 3, 64'hC0); lsu_rd_value_i = 64'h102; tick();
    for (int k = 0; k < 4; k++) begin
      alu_exe_valid_i = 0; lsu_rd_value_i = 64'h103 + 64'(k); #1;
      n_vec++; if (lsu_ready_o !== exp_ready[k]) begin n_err++; $display("FAIL contention_ready[%0d]: got %b want %b", k, lsu_ready_o, exp_ready[k]); end
      n_vec++; if (wb_valid_o !== 1'b1 || wb_rd_value_o !== exp_wb[k]) begin
        n_err++; $display("FAIL contention_wb[%0d]: got v=%b val=%0h want 1/%0h", k, wb_valid_o, wb_rd_value_o, exp_wb[k]); end
      tick();
    end
    lsu_valid_i = 0; #1;
    n_vec++; if (wb_valid_o !== 1'b1 || wb_rd_value_o !== exp_wb[4]) begin
      n_err++; $display("FAIL contention_wb[4]: got v=%b val=%0h want 1/%0h", wb_valid_o, wb_rd_value_o, exp_wb[4]); end
    tick();
  endtask

  task automatic test_fill();
    apply_reset();
    lsu_sid_i = SW'(2); lsu_rd_i = 5'd10;
    for (int c = 0; c < 9; c++) begin
      push_alu(c, c + 1, 64'h200 + 64'(c));
      lsu_valid_i = 1; lsu_rd_value_i = 64'h300 + 64'(c); #1;
      n_vec++; if (alu_almost_full_o !== (c >= 5)) begin n_err++; $display("FAIL fill_almost_full[%0d]: got %b want %b", c, alu_almost_full_o, (c >= 5)); end
      n_vec++; if (err_overflow_o !== 1'b0) begin n_err++; $display("FAIL fill_err_early[%0d]: got %b want 0", c, err_overflow_o); end
      tick();
    end
    idle_inputs(); #1;
    n_vec++; if (err_overflow_o !== 1'b1) begin n_err++; $display("FAIL fill_err_set: got %b want 1", err_overflow_o); end
    tick();
    for (int d = 0; d < 4; d++) begin
      #1;
      n_vec++; if (wb_valid_o !== 1'b1 || wb_rd_value_o !== 64'h204 + 64'(d)) begin
        n_err++; $display("FAIL fill_drain[%0d]: got v=%b val=%0h want 1/%0h", d, wb_valid_o, wb_rd_value_o, 64'h204 + 64'(d)); end
      tick();
    end
    #1;
    n_vec++; if (wb_valid_o !== 1'b0 || err_overflow_o !== 1'b1 || alu_almost_full_o !== 1'b0) begin
      n_err++; $display("FAIL fill_end: got v=%b err=%b af=%b want 0/1/0", wb_valid_o, err_overflow_o, alu_almost_full_o); end
    tick();
  endtask

  task automatic test_rd_x0();
    apply_reset();
    lsu_valid_i = 1; lsu_sid_i = SW'(7); lsu_rd_i = 5'd0; lsu_rd_value_i = 64'h77; #1;
    n_vec++; if (lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", lsu_ready_o); end
    tick();
    lsu_valid_i = 0; #1;
    n_vec++; if (wb_valid_o !== 1'b1 || wb_we_o !== 1'b0 || wb_sid_o !== SW'(7)) begin
      n_err++; $display("FAIL x0_wb: got v=%b we=%b sid=%0d want 1/0/7", wb_valid_o, wb_we_o, wb_sid_o); end
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    lsu_rd_i = 5'd11;
    for (int c = 0; c < 5; c++) begin
      push_alu(c, 1, 64'h400 + 64'(c)); lsu_valid_i = 1; tick();
    end
    push_alu(9, 1, 64'h4FF); flush_i = 1; #1;
    n_vec++; if (lsu_ready_o !== 1'b0 || alu_almost_full_o !== 1'b1) begin
      n_err++; $display("FAIL flush_cycle: got ready=%b af=%b want 0/1", lsu_ready_o, alu_almost_full_o); end
    tick();
    idle_inputs(); #1;
    n_vec++; if (wb_valid_o !== 1'b0 || alu_almost_full_o !== 1'b0 || lsu_ready_o !== 1'b1 || err_overflow_o !== 1'b0) begin
      n_err++; $display("FAIL flush_after: got v=%b af=%b ready=%b err=%b want 0/0/1/0", wb_valid_o, alu_almost_full_o, lsu_ready_o, err_overflow_o); end
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_quiet[%0d]: got %b want 0", c, wb_valid_o); end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    lsu_rd_i = 5'd12; lsu_rd_value_i = 64'h55;
    push_alu(1, 3, 64'h501); tick();
    push_alu(2, 3, 64'h502); lsu_valid_i = 1; tick();
    push_alu(3, 3, 64'h503); tick();
    idle_inputs(); #1;
    rst_n = 0; #1;
    n_vec++; if ({wb_valid_o, wb_we_o, err_overflow_o, alu_almost_full_o} !== 4'b0) begin
      n_err++; $display("FAIL midreset_flags: got v=%b we=%b err=%b af=%b want 0", wb_valid_o, wb_we_o, err_overflow_o, alu_almost_full_o); end
    n_vec++; if ({wb_sid_o, wb_rd_o, wb_rd_value_o} !== '0) begin
      n_err++; $display("FAIL midreset_data: got %0h/%0h/%0h want 0", wb_sid_o, wb_rd_o, wb_rd_value_o); end
    @(posedge clk); #1 rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (wb_valid_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
        n_err++; $display("FAIL midreset_quiet[%0d]: got v=%b ready=%b want 0/1", c, wb_valid_o, lsu_ready_o); end
      tick();
    end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t m_wb, a_e, l_e;
    bit   m_prio, m_err, m_valid, exp_ready, lsu_g, alu_g, fl, av, lv;
    apply_reset();
    m_wb = '0; m_prio = 0; m_err = 0; m_valid = 0;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 19) == 0);
      av = ($urandom_range(0, 1) == 1);
      lv = ($urandom_range(0, 2) != 0);
      a_e = '{sid: SW'($urandom_range(0, 15)), rd: 5'($urandom_range(0, 31)), val: {$urandom(), $urandom()}};
      l_e = '{sid: SW'($urandom_range(0, 15)), rd: 5'($urandom_range(0, 31)), val: {$urandom(), $urandom()}};
      flush_i = fl; alu_exe_valid_i = av; lsu_valid_i = lv;
      alu_sid_i = a_e.sid; alu_exe_rd_i = a_e.rd; alu_exe_rd_value_i = a_e.val;
      lsu_sid_i = l_e.sid; lsu_rd_i = l_e.rd; lsu_rd_value_i = l_e.val;
      #1;
      exp_ready = !fl && (q.size() == 0 || m_prio);
      n_vec++; if (lsu_ready_o !== exp_ready) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, lsu_ready_o, exp_ready); end
      n_vec++; if (alu_almost_full_o !== (q.size() >= DEPTH - 1)) begin n_err++; $display("FAIL rand_af[%0d]: got %b want %b", i, alu_almost_full_o, (q.size() >= DEPTH - 1)); end
      n_vec++; if (wb_valid_o !== m_valid || wb_we_o !== (m_valid && m_wb.rd != 0)) begin
        n_err++; $display("FAIL rand_strobe[%0d]: got v=%b we=%b want %b/%b", i, wb_valid_o, wb_we_o, m_valid, (m_valid && m_wb.rd != 0)); end
      n_vec++; if (wb_sid_o !== m_wb.sid || wb_rd_o !== m_wb.rd || wb_rd_value_o !== m_wb.val) begin
        n_err++; $display("FAIL rand_data[%0d]: got %0h/%0h/%0h want %0h/%0h/%0h", i, wb_sid_o, wb_rd_o, wb_rd_value_o, m_wb.sid, m_wb.rd, m_wb.val); end
      n_vec++; if (err_overflow_o !== m_err) begin n_err++; $display("FAIL rand_err[%0d]: got %b want %b", i, err_overflow_o, m_err); end
      if (fl) begin
        q.delete(); m_prio = 0; m_valid = 0;
      end else begin
        lsu_g = lv && exp_ready;
        alu_g = !lsu_g && q.size() > 0;
        if (lv && q.size() > 0) m_prio = !m_prio;
        m_valid = lsu_g || alu_g;
        if (lsu_g) m_wb = l_e;
        else if (alu_g) m_wb = q.pop_front();
        if (av) begin
          if (q.size() < DEPTH) q.push_back(a_e);
          else m_err = 1;
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1;
    test_reset();
    test_alu_only();
    test_contention();
    test_fill();
    test_rd_x0();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
